// File: rtl/mont_fd_scheduler.sv
// Purpose: job controller for a shared fault-detecting Montgomery core. It loads operands,
//          runs the core in nominal mode and then in encoded mode, compares the two results, and retries on failure.
// Latency: for a fault-free job, rsp_valid rises 2C+6 cycles after the last operand word is accepted (C = core run time).
// Backpressure: in_ready is high only in IDLE/LOAD; rsp_fault and rsp_tries are held with rsp_valid until rsp_ready.
//
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready/bus            operand stream: 2*NW words, u then v, LS word first
//   core_wr_en/_addr/_data           operand RAM write port (one cycle after each accepted word)
//   core_start/core_mode             start pulse, mode 0 = nominal, mode 1 = encoded recompute
//   core_done/core_err/core_sig      completion pulse; err and sig are valid with it
//   rsp_valid/rsp_ready/rsp_fault/rsp_tries   job response
//   busy                             high whenever the FSM is not IDLE
module mont_fd_scheduler #(
    parameter int WORD      = 64,
    parameter int NW        = 16,
    parameter int SIGW      = 80,
    parameter int MAX_RETRY = 2,
    parameter int TIMEOUT   = 8192
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WORD-1:0]           bus,
    output logic                      core_wr_en,
    output logic [$clog2(2*NW)-1:0]   core_wr_addr,
    output logic [WORD-1:0]           core_wr_data,
    output logic                      core_start,
    output logic                      core_mode,
    input  logic                      core_done,
    input  logic                      core_err,
    input  logic [SIGW-1:0]           core_sig,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_fault,
    output logic [1:0]                rsp_tries,
    output logic                      busy
);
    localparam int AW = $clog2(2*NW);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [AW-1:0] LAST_W    = AW'(2*NW-1);
    localparam logic [TW-1:0] TMAX      = TW'(TIMEOUT-1);
    localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_START0, S_WAIT0, S_START1, S_WAIT1, S_CHECK, S_FAIL, S_RESP
    } state_t;

    state_t            state_q;
    logic [AW-1:0]     cnt_q;
    logic [TW-1:0]     timer_q;
    logic [1:0]        tries_q;
    logic [SIGW-1:0]   sig0_q, sig1_q;
    logic              err0_q, err1_q;

    logic              in_ready_q, core_wr_en_q, core_start_q, core_mode_q;
    logic [AW-1:0]     core_wr_addr_q;
    logic [WORD-1:0]   core_wr_data_q;
    logic              rsp_valid_q, rsp_fault_q, busy_q;
    logic [1:0]        rsp_tries_q;

    assign in_ready     = in_ready_q;
    assign core_wr_en   = core_wr_en_q;
    assign core_wr_addr = core_wr_addr_q;
    assign core_wr_data = core_wr_data_q;
    assign core_start   = core_start_q;
    assign core_mode    = core_mode_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_fault    = rsp_fault_q;
    assign rsp_tries    = rsp_tries_q;
    assign busy         = busy_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            timer_q        <= '0;
            tries_q        <= '0;
            sig0_q         <= '0;
            sig1_q         <= '0;
            err0_q         <= 1'b0;
            err1_q         <= 1'b0;
            in_ready_q     <= 1'b0;
            core_wr_en_q   <= 1'b0;
            core_wr_addr_q <= '0;
            core_wr_data_q <= '0;
            core_start_q   <= 1'b0;
            core_mode_q    <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_fault_q    <= 1'b0;
            rsp_tries_q    <= '0;
            busy_q         <= 1'b0;
        end else begin
            // Write strobe and start are single-cycle pulses.
            core_wr_en_q <= 1'b0;
            core_start_q <= 1'b0;
            case (state_q)
                // IDLE and LOAD share the accept path. cnt_q is zero in IDLE, so the
                // first word lands at address 0.
                S_IDLE, S_LOAD: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        core_wr_en_q   <= 1'b1;
                        core_wr_addr_q <= cnt_q;
                        core_wr_data_q <= bus;
                        cnt_q          <= cnt_q + 1'b1;   // wraps to 0 after the last word
                        busy_q         <= 1'b1;
                        if (cnt_q == LAST_W) begin
                            in_ready_q <= 1'b0;
                            state_q    <= S_START0;
                        end else begin
                            state_q    <= S_LOAD;
                        end
                    end
                end
                S_START0, S_START1: begin
                    core_mode_q  <= (state_q == S_START1);
                    core_start_q <= 1'b1;
                    timer_q      <= '0;
                    state_q      <= (state_q == S_START1) ? S_WAIT1 : S_WAIT0;
                end
                // core_done takes priority over timer expiry on the same cycle.
                S_WAIT0, S_WAIT1: begin
                    if (core_done) begin
                        if (state_q == S_WAIT0) begin
                            sig0_q  <= core_sig;
                            err0_q  <= core_err;
                            state_q <= S_START1;
                        end else begin
                            sig1_q  <= core_sig;
                            err1_q  <= core_err;
                            state_q <= S_CHECK;
                        end
                    end else if (timer_q == TMAX) begin
                        state_q <= S_FAIL;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_CHECK: begin
                    if ((sig0_q == sig1_q) && !err0_q && !err1_q) begin
                        rsp_valid_q <= 1'b1;
                        rsp_fault_q <= 1'b0;
                        rsp_tries_q <= tries_q;
                        state_q     <= S_RESP;
                    end else begin
                        state_q     <= S_FAIL;
                    end
                end
                // The retry reruns the core without reloading: its RAM still holds the operands.
                S_FAIL: begin
                    if (tries_q < RETRY_MAX) begin
                        tries_q <= tries_q + 1'b1;
                        state_q <= S_START0;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        rsp_fault_q <= 1'b1;
                        rsp_tries_q <= tries_q;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        tries_q     <= '0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mont_fd_scheduler.sv
// Purpose: self-checking bench for mont_fd_scheduler. It uses a behavioural core model,
//          a table of jobs, and scoreboards for operand writes and responses.
// Latency: the bench measures response latency and the spacing between start pulses against expected values.
// Backpressure: the bench toggles in_valid during the load and holds rsp_ready low while checking that the response is stable.
module tb_mont_fd_scheduler;
    localparam int TIMEOUT = 8192;
    localparam int FM_OK = 0, FM_TRANS = 1, FM_ERR = 2, FM_TMO = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [63:0] bus;
    logic        core_wr_en;
    logic [4:0]  core_wr_addr;
    logic [63:0] core_wr_data;
    logic        core_start, core_mode;
    logic        core_done, core_err;
    logic [79:0] core_sig;
    logic        rsp_valid, rsp_ready, rsp_fault;
    logic [1:0]  rsp_tries;
    logic        busy;

    mont_fd_scheduler #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .bus(bus),
        .core_wr_en(core_wr_en), .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data),
        .core_start(core_start), .core_mode(core_mode),
        .core_done(core_done), .core_err(core_err), .core_sig(core_sig),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_fault(rsp_fault),
        .rsp_tries(rsp_tries), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [4:0] addr; logic [63:0] data; } wr_t;
    typedef struct { logic fault; logic [1:0] tries; } rsp_t;
    typedef struct { int fm; int c; bit gap; int hold; bit fault; int tries; int starts; } job_t;

    wr_t  wr_q[$];
    rsp_t rsp_q[$];
    job_t jobs[6];

    int n_chk = 0, n_err = 0;
    int cyc = 0, last_acc = 0, start_cnt = 0, mdl_n = 0;
    int cur_fm = FM_OK, cur_c = 0;
    int st_cyc[8];
    bit core_kill = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Behavioural core: done arrives C cycles after the start pulse, and never arrives in timeout mode.
    // In transient mode the recompute of the first attempt returns a different signature.
    initial begin
        core_done = 0; core_err = 0; core_sig = '0;
        forever begin
            @(negedge clk);
            if (core_start && reset) begin
                mdl_n++;
                if (cur_fm != FM_TMO) begin
                    for (int i = 0; i < cur_c && !core_kill; i++) @(negedge clk);
                    if (!core_kill) begin
                        core_done = 1;
                        core_err  = (cur_fm == FM_ERR);
                        core_sig  = (cur_fm == FM_TRANS && mdl_n == 2) ? 80'h5B : 80'h5A;
                        @(negedge clk);
                        core_done = 0;
                        core_err  = 0;
                    end
                end
            end
        end
    end

    // Write scoreboard and start-pulse monitor.
    always @(negedge clk) begin
        if (reset) begin
            if (core_wr_en) begin
                if (wr_q.size() == 0) check("unexpected_write", 80'(core_wr_addr), 80'h7F);
                else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    check("wr_addr", 80'(core_wr_addr), 80'(e.addr));
                    check("wr_data", 80'(core_wr_data), 80'(e.data));
                end
            end
            if (core_start) begin
                if (start_cnt < 8) st_cyc[start_cnt] = cyc;
                check("start_mode", 80'(core_mode), (cur_fm == FM_TMO) ? 80'(0) : 80'(start_cnt % 2));
                start_cnt++;
            end
        end
    end

    task automatic send_words(input int jidx, input bit gap);
        int  w = 0, guard = 0;
        bit  ph = 0;
        wr_t e;
        while (w < 32 && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (gap && ph) begin
                in_valid = 0;
                ph = 0;
            end else begin
                in_valid = 1;
                bus = (64'(jidx) << 32) | 64'(w + 1);
                if (in_ready) begin
                    e.addr = 5'(w);
                    e.data = bus;
                    wr_q.push_back(e);
                    last_acc = cyc;
                    w++;
                    ph = gap;
                end
            end
        end
        if (w < 32) check("load_stall", 80'(w), 80'(32));
        // Offer a 33rd word; it must not be taken.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1;
            bus = 64'hDEAD_BEEF_0000_0000;
            check("in_ready_after_last", 80'(in_ready), 80'(0));
        end
        in_valid = 0;
    endtask

    task automatic run_job(input job_t j, input int jidx);
        int   guard = 0;
        rsp_t r, e;
        cur_fm = j.fm; cur_c = j.c; mdl_n = 0; start_cnt = 0;
        r.fault = j.fault; r.tries = 2'(j.tries);
        rsp_q.push_back(r);
        send_words(jidx, j.gap);
        while (!rsp_valid && guard < 40000) begin
            @(negedge clk);
            guard++;
        end
        if (!rsp_valid) begin
            check("rsp_wait_timeout", 80'(0), 80'(1));
            void'(rsp_q.pop_front());
            return;
        end
        if (j.starts == 2) check("latency", 80'(cyc - last_acc), 80'(2 * j.c + 6));
        check("start_count", 80'(start_cnt), 80'(j.starts));
        check("start_spacing", 80'(st_cyc[1] - st_cyc[0]),
              80'(((j.fm == FM_TMO) ? TIMEOUT : j.c) + 2));
        check("busy_in_resp", 80'(busy), 80'(1));
        for (int i = 0; i < j.hold; i++) begin
            check("hold_valid", 80'(rsp_valid), 80'(1));
            check("hold_fault", 80'(rsp_fault), 80'(j.fault));
            check("hold_tries", 80'(rsp_tries), 80'(j.tries));
            check("hold_in_ready", 80'(in_ready), 80'(0));
            @(negedge clk);
        end
        rsp_ready = 1;
        e = rsp_q.pop_front();
        check("rsp_fault", 80'(rsp_fault), 80'(e.fault));
        check("rsp_tries", 80'(rsp_tries), 80'(e.tries));
        @(negedge clk);
        rsp_ready = 0;
        check("post_rsp_valid", 80'(rsp_valid), 80'(0));
        check("post_rsp_in_ready", 80'(in_ready), 80'(1));
        check("post_rsp_busy", 80'(busy), 80'(0));
        check("writes_drained", 80'(wr_q.size()), 80'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},   80'(in_ready),   80'(0));
        check({tag, "_wr_en"},      80'(core_wr_en), 80'(0));
        check({tag, "_start"},      80'(core_start), 80'(0));
        check({tag, "_mode"},       80'(core_mode),  80'(0));
        check({tag, "_rsp_valid"},  80'(rsp_valid),  80'(0));
        check({tag, "_rsp_fault"},  80'(rsp_fault),  80'(0));
        check({tag, "_rsp_tries"},  80'(rsp_tries),  80'(0));
        check({tag, "_busy"},       80'(busy),       80'(0));
    endtask

    initial begin
        int guard;
        //           fm        c     gap hold fault tries starts
        jobs[0] = '{FM_OK,    100,   0,  0,   0,    0,    2};
        jobs[1] = '{FM_TRANS, 20,    0,  0,   0,    1,    4};
        jobs[2] = '{FM_ERR,   15,    0,  0,   1,    2,    6};
        jobs[3] = '{FM_TMO,   0,     0,  0,   1,    2,    3};
        jobs[4] = '{FM_OK,    TIMEOUT-1, 0, 0, 0,   0,    2};
        jobs[5] = '{FM_OK,    30,    1,  20,  0,    0,    2};

        reset = 0; in_valid = 0; bus = '0; rsp_ready = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1;

        for (int k = 0; k < 6; k++) run_job(jobs[k], k);

        // Reset pulse during the recompute run aborts the job without producing a response.
        cur_fm = FM_OK; cur_c = 100; mdl_n = 0; start_cnt = 0;
        send_words(6, 0);
        guard = 0;
        while (start_cnt < 2 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("reached_wait1", 80'(start_cnt), 80'(2));
        repeat (10) @(negedge clk);
        core_kill = 1;
        reset = 0;
        #1;
        check_reset_outputs("midjob_reset");
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        core_kill = 0;
        check("no_rsp_after_reset", 80'(rsp_valid), 80'(0));
        run_job(jobs[0], 7);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
